// File: rtl/fifo_sync_pkg.sv
// Shared helpers for the asynchronous FIFO pointer synchronisers.
// Gray/binary conversions work on zero-extended values up to PTR_W_MAX bits.
package fifo_sync_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int PTR_W_MAX       = 32;

  // Callers zero-extend their pointer and cast the result back to width.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
    logic [PTR_W_MAX-1:0] bin;
    bin = '0;
    for (int i = 0; i < PTR_W_MAX; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic N-stage, W-bit synchroniser flop chain with synchronous active-high reset.
// Stage 0 samples the asynchronous input; there is deliberately no logic between stages.
module sync_chain #(
  parameter int N = 2,
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk) begin
          if (i_srst) r_stage[gi] <= '0;
          else        r_stage[gi] <= i_d;
        end
      end else begin : g_next
        always_ff @(posedge i_clk) begin
          if (i_srst) r_stage[gi] <= '0;
          else        r_stage[gi] <= r_stage[gi-1];
        end
      end
    end
  endgenerate

  assign o_q = r_stage[N-1];

endmodule

// File: rtl/gray_pointer_sync_rd.sv
// Read-domain receiver for the Gray write pointer: synchronise, convert to binary,
// derive fill/empty/almost-empty against the local read pointer, flag illegal pointers.
module gray_pointer_sync_rd
  import fifo_sync_pkg::*;
#(
  parameter int address_size       = 3,
  parameter int sync_stages        = 2,
  parameter int almost_empty_level = 1
) (
  input  logic                    read_clk_i,
  input  logic                    read_reset_i,
  input  logic [address_size:0]   write_pointer_gray_i,
  input  logic [address_size:0]   read_pointer_bin_i,
  output logic [address_size:0]   write_pointer_sync_gray_o,
  output logic [address_size:0]   write_pointer_sync_bin_o,
  output logic [address_size:0]   fill_level_o,
  output logic                    empty_o,
  output logic                    almost_empty_o,
  output logic                    pointer_advance_o,
  output logic                    pointer_error_o
);

  localparam int PTR_W = address_size + 1;
  localparam int DEPTH = 1 << address_size;

  generate
    if (sync_stages < MIN_SYNC_STAGES || sync_stages > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("gray_pointer_sync_rd: sync_stages out of range");
    end
    if (almost_empty_level < 0 || almost_empty_level > DEPTH - 1) begin : g_bad_level
      $error("gray_pointer_sync_rd: almost_empty_level out of range");
    end
  endgenerate

  logic [PTR_W-1:0] w_last_gray;
  logic [PTR_W-1:0] w_last_bin;
  logic [PTR_W-1:0] w_gray_of_bin;
  logic [PTR_W-1:0] w_gray_diff;
  logic [PTR_W-1:0] w_fill_raw;
  logic             w_illegal_step;
  logic             w_overflow;

  logic [PTR_W-1:0] r_bin;
  logic             r_adv;
  logic             r_err;

  sync_chain #(
    .N (sync_stages),
    .W (PTR_W)
  ) u_sync_chain (
    .i_clk  (read_clk_i),
    .i_srst (read_reset_i),
    .i_d    (write_pointer_gray_i),
    .o_q    (w_last_gray)
  );

  assign w_last_bin    = PTR_W'(gray2bin(PTR_W_MAX'(w_last_gray)));
  assign w_gray_of_bin = PTR_W'(bin2gray(PTR_W_MAX'(r_bin)));
  assign w_gray_diff   = w_last_gray ^ w_gray_of_bin;
  // More than one differing bit: clearing the lowest set bit leaves something.
  assign w_illegal_step = (w_gray_diff & (w_gray_diff - 1'b1)) != '0;

  assign w_fill_raw = r_bin - read_pointer_bin_i;
  assign w_overflow = w_fill_raw > PTR_W'(DEPTH);

  always_ff @(posedge read_clk_i) begin
    if (read_reset_i) begin
      r_bin <= '0;
      r_adv <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_bin <= w_last_bin;
      r_adv <= (w_last_bin != r_bin);
      r_err <= r_err | w_illegal_step | w_overflow;
    end
  end

  // Flags are forced during reset independent of the live read pointer.
  assign fill_level_o   = read_reset_i ? '0 : w_fill_raw;
  assign empty_o        = (fill_level_o == '0);
  assign almost_empty_o = (fill_level_o <= PTR_W'(almost_empty_level));

  assign write_pointer_sync_gray_o = w_last_gray;
  assign write_pointer_sync_bin_o  = r_bin;
  assign pointer_advance_o         = r_adv;
  assign pointer_error_o           = r_err;

endmodule

// File: tb/tb_gray_pointer_sync_rd.sv
// Bench for gray_pointer_sync_rd: directed vector table, corner-case sequences,
// and randomised pointer traffic against a delay-line reference model.
module tb_gray_pointer_sync_rd;

  localparam int A  = 3;
  localparam int NS = 2;
  localparam int AE = 1;
  localparam int PW = A + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] wg;
  logic [PW-1:0] rd;
  logic [PW-1:0] o_gray, o_bin, o_fill;
  logic          o_empty, o_ae, o_adv, o_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the last NS input samples, registered binary, flags.
  logic [PW-1:0] m_hist [NS];
  logic [PW-1:0] m_bin;
  logic          m_adv, m_err;

  typedef struct {
    logic          rst;
    logic [PW-1:0] wg, rd;
    logic [PW-1:0] e_gray, e_bin, e_fill;
    logic          e_empty, e_ae, e_adv, e_err;
  } vec_t;
  vec_t vecs [12];

  always #5 clk = ~clk;

  gray_pointer_sync_rd #(
    .address_size       (A),
    .sync_stages        (NS),
    .almost_empty_level (AE)
  ) dut (
    .read_clk_i                (clk),
    .read_reset_i              (rst),
    .write_pointer_gray_i      (wg),
    .read_pointer_bin_i        (rd),
    .write_pointer_sync_gray_o (o_gray),
    .write_pointer_sync_bin_o  (o_bin),
    .fill_level_o              (o_fill),
    .empty_o                   (o_empty),
    .almost_empty_o            (o_ae),
    .pointer_advance_o         (o_adv),
    .pointer_error_o           (o_err)
  );

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [PW-1:0] to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int k = 0; k < PW; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic int ones(input logic [PW-1:0] v);
    int c;
    c = 0;
    for (int k = 0; k < PW; k++) c += int'(v[k]);
    return c;
  endfunction

  function automatic int model_fill();
    if (rst) return 0;
    return (int'(m_bin) - int'(rd)) & ((1 << PW) - 1);
  endfunction

  function automatic logic [15:0] dut_vec();
    return {o_gray, o_bin, o_fill, o_empty, o_ae, o_adv, o_err};
  endfunction

  function automatic logic [15:0] model_vec();
    int f;
    f = model_fill();
    return {m_hist[NS-1], m_bin, PW'(f), f == 0, f <= AE, m_adv, m_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [PW-1:0] nb;
    if (rst) begin
      for (int k = 0; k < NS; k++) m_hist[k] = '0;
      m_bin = '0; m_adv = 1'b0; m_err = 1'b0;
    end else begin
      if (ones(m_hist[NS-1] ^ to_gray(int'(m_bin))) > 1 || model_fill() > (1 << A))
        m_err = 1'b1;
      nb    = to_bin(m_hist[NS-1]);
      m_adv = (nb != m_bin);
      m_bin = nb;
      for (int k = NS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = wg;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", 32'(dut_vec()), 32'(model_vec()));
    $display("cyc t=%0t rst=%0b wg=%b rd=%b gray=%b bin=%b fill=%0d e=%0b ae=%0b adv=%0b err=%0b",
             $time, rst, wg, rd, o_gray, o_bin, o_fill, o_empty, o_ae, o_adv, o_err);
  endtask

  task automatic set_rd_comb(input logic [PW-1:0] r, input int exp_fill, input string name);
    rd = r;
    #1;
    chk(name, 32'({o_fill, o_empty}), 32'({PW'(exp_fill), exp_fill == 0}));
  endtask

  task automatic do_reset();
    rst = 1'b1; wg = '0; rd = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'b0110, 4'd0, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0110, 4'd0, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0110, 4'd0, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0110, 4'd0, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0110, 4'd0, 4'b0110, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    // Jump from reset value 0000 to 0110 is a two-bit Gray step.
    vecs[5]  = '{1'b0, 4'b0110, 4'd0, 4'b0110, 4'b0100, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 4'b0000, 4'd0, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0001, 4'd0, 4'b0000, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0011, 4'd0, 4'b0001, 4'b0000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b0011, 4'd0, 4'b0011, 4'b0001, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0011, 4'd0, 4'b0011, 4'b0010, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0011, 4'd0, 4'b0011, 4'b0010, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < NS; k++) m_hist[k] = '0;
    m_bin = '0; m_adv = 1'b0; m_err = 1'b0;
    rst = 1'b1; wg = '0; rd = '0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; wg = vecs[i].wg; rd = vecs[i].rd;
      step();
      chk($sformatf("vec%0d", i), 32'(dut_vec()),
          32'({vecs[i].e_gray, vecs[i].e_bin, vecs[i].e_fill,
               vecs[i].e_empty, vecs[i].e_ae, vecs[i].e_adv, vecs[i].e_err}));
    end

    // Wrap-around: walk legally to 14, then 14 -> 15 -> 0 against read pointer 13.
    do_reset();
    for (int w = 1; w <= 14; w++) begin
      wg = to_gray(w); rd = PW'((w >= 5) ? w - 5 : 0);
      step();
    end
    for (int k = 0; k < 4; k++) step();
    set_rd_comb(4'd13, 1, "wrap_fill1");
    step();
    wg = to_gray(15); step();
    wg = to_gray(0);
    for (int k = 0; k < 4; k++) step();
    chk("wrap_end", 32'({o_bin, o_fill, o_err}), 32'({4'b0000, 4'd3, 1'b0}));

    // Static write pointer 5, read pointer catches up combinationally.
    do_reset();
    for (int w = 1; w <= 5; w++) begin wg = to_gray(w); step(); end
    for (int k = 0; k < 3; k++) step();
    chk("static_bin", 32'(o_bin), 32'd5);
    set_rd_comb(4'd3, 2, "rd3_fill"); step();
    set_rd_comb(4'd4, 1, "rd4_fill"); step();
    set_rd_comb(4'd5, 0, "rd5_fill"); step();

    // Illegal Gray jump 0000 -> 0011: error at edge NS+1, then sticky.
    do_reset();
    wg = 4'b0011;
    step(); step();
    chk("jump_err_e2", 32'(o_err), 32'd0);
    step();
    chk("jump_err_e3", 32'(o_err), 32'd1);
    step(); step();
    chk("jump_err_sticky", 32'(o_err), 32'd1);

    // Overflow: synced binary 9 against read pointer 0.
    do_reset();
    for (int w = 1; w <= 9; w++) begin wg = to_gray(w); step(); end
    for (int k = 0; k < 4; k++) step();
    chk("ovf_err", 32'({o_bin, o_err}), 32'({4'd9, 1'b1}));

    // Reset mid-operation clears everything, then the chain refills.
    set_rd_comb(4'd6, 3, "pre_reset_fill3");
    rst = 1'b1;
    step();
    chk("mid_reset", 32'(dut_vec()), 32'({4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0; rd = '0;
    for (int k = 0; k < 5; k++) step();

    // Randomised legal traffic with occasional illegal jumps and resets.
    begin
      int wb;
      do_reset();
      wb = 0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 59) == 0) begin
          rst = 1'b1; wb = 0; wg = '0; rd = '0;
        end else begin
          rst = 1'b0;
          if ($urandom_range(0, 1) == 1 && model_fill() + 3 < (1 << A)) wb++;
          wg = to_gray(wb);
          if ($urandom_range(0, 79) == 0) wg = PW'($urandom);
          if ($urandom_range(0, 1) == 1 && model_fill() > 0) rd = rd + 1'b1;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
